id_ex_stage: RTL

- ID/EX pipeline register of the 5-stage RV32I core. Sits directly upstream of the ALU and drives its a, b and alu_control inputs.
- Captures decoded operands and control from ID, then applies EX/MEM and MEM/WB forwarding to select the ALU operands.
- Detects load-use hazards and inserts bubbles. Supports hold (stall) and flush.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/id_ex_stage_fwd_mux.sv | 34 +++
 rtl/id_ex_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, ALU opcodes and the
// EX-stage control bundle with its bubble value.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned RA_W_DEFAULT = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Control carried alongside the instruction into EX
  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } ctrl_t;

  // A bubble has no side effects: every control field is zero
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: EX/MEM result beats MEM/WB result beats the
// register value; x0 is never forwarded.
module fwd_mux #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] i_rs,
  input  logic [XLEN-1:0] i_rs_data,
  input  logic            i_exmem_reg_write,
  input  logic [RA_W-1:0] i_exmem_rd,
  input  logic [XLEN-1:0] i_exmem_result,
  input  logic            i_memwb_reg_write,
  input  logic [RA_W-1:0] i_memwb_rd,
  input  logic [XLEN-1:0] i_memwb_result,
  output logic [XLEN-1:0] o_fwd_data_c
);

  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_hit_exmem = i_exmem_reg_write & (i_exmem_rd != '0) & (i_exmem_rd == i_rs);
  assign w_hit_memwb = i_memwb_reg_write & (i_memwb_rd != '0) & (i_memwb_rd == i_rs);

  // Priority select of the freshest producer
  always_comb begin
    o_fwd_data_c = i_rs_data;
    if (w_hit_exmem) begin
      o_fwd_data_c = i_exmem_result;
    end else if (w_hit_memwb) begin
      o_fwd_data_c = i_memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble
// insertion, hold and flush. Optional bubble counter: ID_EX_PERF_CNT_EN.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned RA_W = RA_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alu_control,
  input  logic            id_alu_src_imm,
  input  logic            id_alu_src_pc,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            load_use_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]     bubble_count
`endif
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [RA_W-1:0] r_rd;
  ctrl_t           r_ctrl;

  ctrl_t           w_id_ctrl;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic            w_load_use;

  // Gather ID control into one bundle
  always_comb begin
    w_id_ctrl             = CTRL_BUBBLE;
    w_id_ctrl.alu_control = id_alu_control;
    w_id_ctrl.alu_src_imm = id_alu_src_imm;
    w_id_ctrl.alu_src_pc  = id_alu_src_pc;
    w_id_ctrl.reg_write   = id_reg_write;
    w_id_ctrl.mem_read    = id_mem_read;
    w_id_ctrl.mem_write   = id_mem_write;
    w_id_ctrl.mem_to_reg  = id_mem_to_reg;
  end

  assign w_load_use = r_valid & r_ctrl.mem_read & (r_rd != '0) & id_valid &
                      ((r_rd == id_rs1) | (r_rd == id_rs2));

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .i_rs              (r_rs1),
    .i_rs_data         (r_rs1_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_fwd_data_c      (w_fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .i_rs              (r_rs2),
    .i_rs_data         (r_rs2_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_fwd_data_c      (w_fwd_rs2)
  );

  // Pipeline register: flush > stall (hold + refresh) > load-use bubble > capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= CTRL_BUBBLE;
    end else if (flush || (!stall && w_load_use)) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= CTRL_BUBBLE;
    end else if (stall) begin
      // keep writes that retire during the hold
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end else begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_ctrl     <= id_valid ? w_id_ctrl : CTRL_BUBBLE;
    end
  end

  assign alu_a          = r_ctrl.alu_src_pc  ? r_pc  : w_fwd_rs1;
  assign alu_b          = r_ctrl.alu_src_imm ? r_imm : w_fwd_rs2;
  assign alu_control    = r_ctrl.alu_control;
  assign ex_store_data  = w_fwd_rs2;
  assign ex_valid       = r_valid;
  assign ex_pc          = r_pc;
  assign ex_rd          = r_rd;
  assign ex_reg_write   = r_ctrl.reg_write;
  assign ex_mem_read    = r_ctrl.mem_read;
  assign ex_mem_write   = r_ctrl.mem_write;
  assign ex_mem_to_reg  = r_ctrl.mem_to_reg;
  assign load_use_stall = w_load_use;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_count;

  // Count bubbles inserted by flush or load-use; holds do not count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_count <= '0;
    end else if (flush || (!stall && w_load_use)) begin
      r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign bubble_count = r_bubble_count;
`endif

endmodule
